bootloader_ctrl: RTL and testbench



---
 rtl/bootloader_ctrl.sv | 153 +++++++++++++++
 tb/tb_bootloader_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootloader_ctrl.sv
// ============================================================================
// Module   : bootloader_ctrl
// Purpose  : Loads the CPU instruction memory from slow asynchronous host pins,
//            issuing one single-cycle memory write per host strobe edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bootloader_ctrl #(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            prog_req_i,
    input  logic                            strobe_i,
    input  logic [REGISTER_WIDTH-1:0]       data_pins_i,
    output logic                            bl_programm_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
    output logic [REGISTER_WIDTH-1:0]       bl_data_o,
    output logic                            bl_write_en_mem_o,
    output logic                            busy_o,
    output logic                            done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] c_LAST_ADDR =
        MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] c_ADDR_ONE =
        MEMORY_ADDRESS_WIDTH'(1);

    state_t                            r_state;
    state_t                            w_state_next;
    logic [SYNC_STAGES-1:0]            r_req_sync;
    logic [SYNC_STAGES-1:0]            r_strobe_sync;
    logic [REGISTER_WIDTH-1:0]         r_data_sync [SYNC_STAGES];
    logic                              r_strobe_prev;
    logic [MEMORY_ADDRESS_WIDTH-1:0]   r_addr;
    logic [REGISTER_WIDTH-1:0]         r_data;

    logic w_req;
    logic w_strobe;
    logic w_strobe_edge;
    logic w_latch;
    logic w_addr_inc;
    logic w_clear;

    assign w_req         = r_req_sync[SYNC_STAGES-1];
    assign w_strobe      = r_strobe_sync[SYNC_STAGES-1];
    assign w_strobe_edge = w_strobe & ~r_strobe_prev;

    // Data runs through the same depth as the strobe so both arrive together.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_req_sync    <= '0;
            r_strobe_sync <= '0;
            r_strobe_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
        end else begin
            r_req_sync    <= {r_req_sync[SYNC_STAGES-2:0], prog_req_i};
            r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], strobe_i};
            r_strobe_prev <= w_strobe;
            r_data_sync[0] <= data_pins_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_addr <= '0;
                r_data <= '0;
            end else begin
                if (w_addr_inc) begin
                    r_addr <= r_addr + c_ADDR_ONE;
                end
                if (w_latch) begin
                    r_data <= r_data_sync[SYNC_STAGES-1];
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_addr_inc   = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear = 1'b1;
                if (w_req) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A dropped request beats a coincident strobe edge.
                if (!w_req) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end else if (w_strobe_edge) begin
                    w_state_next = S_WRITE;
                    w_latch      = 1'b1;
                end
            end
            S_WRITE: begin
                if (r_addr == c_LAST_ADDR) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_LOAD;
                    w_addr_inc   = 1'b1;
                end
            end
            S_DONE: begin
                if (!w_req) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_clear      = 1'b1;
            end
        endcase
    end

    assign bl_programm_o     = (r_state != S_IDLE);
    assign bl_write_en_mem_o = (r_state == S_WRITE);
    assign busy_o            = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done_o            = (r_state == S_DONE);
    assign bl_address_o      = r_addr;
    assign bl_data_o         = r_data;

endmodule

`default_nettype wire

// File: tb/tb_bootloader_ctrl.sv
// ============================================================================
// Module   : tb_bootloader_ctrl
// Purpose  : Self-checking bench for bootloader_ctrl against a session-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bootloader_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       prog_req;
    logic       strobe;
    logic [3:0] data_pins;
    logic       bl_programm;
    logic [3:0] bl_address;
    logic [3:0] bl_data;
    logic       bl_we;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int act_log[$];
    int exp_log[$];
    int run_len = 0;
    int max_run = 0;
    bit busy_seen = 0;

    int m_mode = M_IDLE;
    int m_addr = 0;

    always #5 clk = ~clk;

    bootloader_ctrl dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .prog_req_i        (prog_req),
        .strobe_i          (strobe),
        .data_pins_i       (data_pins),
        .bl_programm_o     (bl_programm),
        .bl_address_o      (bl_address),
        .bl_data_o         (bl_data),
        .bl_write_en_mem_o (bl_we),
        .busy_o            (busy),
        .done_o            (done)
    );

    // Write monitor: logs every write-pulse cycle as {address, data}.
    always @(posedge clk) begin
        #1;
        if (busy) busy_seen = 1;
        if (bl_we) begin
            act_log.push_back(int'({bl_address, bl_data}));
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Session-level reference: a loading session stores words at consecutive addresses.
    function automatic void model_req(input bit r);
        prog_req = r;
        if (!r) begin
            m_mode = M_IDLE;
            m_addr = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_LOAD;
        end
    endfunction

    function automatic void model_strobe(input logic [3:0] d);
        if (m_mode == M_LOAD) begin
            exp_log.push_back(m_addr * 16 + int'(d));
            if (m_addr == 15) m_mode = M_DONE;
            else m_addr++;
        end
    endfunction

    task automatic send_strobe(input logic [3:0] d);
        data_pins = d;
        tick(1);
        strobe = 1'b1;
        tick(3 + int'($urandom_range(0, 2)));
        strobe = 1'b0;
        tick(3 + int'($urandom_range(0, 2)));
        model_strobe(d);
    endtask

    task automatic clear_logs();
        act_log.delete();
        exp_log.delete();
        max_run = 0;
        busy_seen = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; prog_req = 1'b0; strobe = 1'b0; data_pins = 4'h0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        checks++;
        if ({bl_programm, bl_we, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bl_programm, bl_we, busy, done});
        end
        checks++;
        if (bl_address !== 4'h0) begin
            errors++;
            $display("FAIL reset_address: got %h expected 0", bl_address);
        end
        checks++;
        if (bl_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", bl_data);
        end
    endtask

    task automatic test_request_latency();
        int lat = 0;
        model_req(1);
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick(1);
            if (bl_programm === 1'b1) lat = i;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL request_latency: got %0d edges expected 3", lat);
        end
        checks++;
        if ({busy, done, bl_we} !== 3'b100) begin
            errors++;
            $display("FAIL load_flags: got %b expected 100", {busy, done, bl_we});
        end
    endtask

    task automatic test_full_load();
        clear_logs();
        for (int i = 0; i < 16; i++) send_strobe(4'($urandom));
        checks++;
        if (act_log.size() != exp_log.size()) begin
            errors++;
            $display("FAIL full_load_count: got %0d expected %0d", act_log.size(), exp_log.size());
        end
        foreach (exp_log[i]) if (i < act_log.size()) begin
            checks++;
            if (act_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL full_load_word%0d: got %h expected %h", i, act_log[i], exp_log[i]);
            end
        end
        checks++;
        if (max_run != 1) begin
            errors++;
            $display("FAIL full_load_pulse_width: got %0d expected 1", max_run);
        end
        checks++;
        if ({done, busy, bl_programm, bl_address} !== {3'b101, 4'hF}) begin
            errors++;
            $display("FAIL full_load_done: got %b expected 1011111", {done, busy, bl_programm, bl_address});
        end
    endtask

    task automatic test_done_strobes();
        clear_logs();
        for (int i = 0; i < 3; i++) send_strobe(4'($urandom));
        checks++;
        if (act_log.size() != 0) begin
            errors++;
            $display("FAIL done_extra_writes: got %0d expected 0", act_log.size());
        end
        checks++;
        if ({done, bl_address} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL done_hold: got %b expected 11111", {done, bl_address});
        end
    endtask

    task automatic test_release_latency();
        int lat = 0;
        model_req(0);
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick(1);
            if (bl_programm === 1'b0) lat = i;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL release_latency: got %0d edges expected 3", lat);
        end
        checks++;
        if ({done, bl_address} !== 5'b0) begin
            errors++;
            $display("FAIL release_idle: got %b expected 00000", {done, bl_address});
        end
    endtask

    task automatic test_abort();
        clear_logs();
        model_req(1);
        tick(4);
        for (int i = 0; i < 5; i++) send_strobe(4'hA);
        model_req(0);
        tick(3);
        checks++;
        if ({bl_programm, busy, bl_address} !== 6'b0) begin
            errors++;
            $display("FAIL abort_idle: got %b expected 000000", {bl_programm, busy, bl_address});
        end
        model_req(1);
        tick(4);
        send_strobe(4'($urandom));
        checks++;
        if (act_log.size() != exp_log.size()) begin
            errors++;
            $display("FAIL abort_count: got %0d expected %0d", act_log.size(), exp_log.size());
        end
        foreach (exp_log[i]) if (i < act_log.size()) begin
            checks++;
            if (act_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL abort_word%0d: got %h expected %h", i, act_log[i], exp_log[i]);
            end
        end
        model_req(0);
        tick(5);
    endtask

    task automatic test_idle_strobe();
        clear_logs();
        for (int i = 0; i < 4; i++) send_strobe(4'($urandom));
        checks++;
        if (act_log.size() != 0 || busy_seen) begin
            errors++;
            $display("FAIL idle_strobe: got writes=%0d busy_seen=%0d expected 0 0", act_log.size(), busy_seen);
        end
    endtask

    task automatic test_reset_mid_load();
        int lat = 0;
        bit seen = 0;
        logic [3:0] d;
        clear_logs();
        model_req(1);
        tick(4);
        for (int i = 0; i < 7; i++) send_strobe(4'($urandom));
        d = 4'($urandom);
        data_pins = d;
        tick(1);
        strobe = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            if (bl_we === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_wait: got no write pulse expected one within 10 cycles");
        end
        model_strobe(d);
        reset_n = 1'b0;
        strobe = 1'b0;
        tick(1);
        reset_n = 1'b1;
        m_mode = M_LOAD;
        m_addr = 0;
        checks++;
        if ({bl_programm, bl_we, busy, done, bl_address, bl_data} !== 12'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected all 0",
                     {bl_programm, bl_we, busy, done, bl_address, bl_data});
        end
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick(1);
            if (busy === 1'b1) lat = i;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL reset_reentry_latency: got %0d expected 3", lat);
        end
        checks++;
        if (act_log.size() != exp_log.size() || max_run != 1) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d run %0d expected %0d run 1",
                     act_log.size(), max_run, exp_log.size());
        end
        foreach (exp_log[i]) if (i < act_log.size()) begin
            checks++;
            if (act_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL reset_mid_word%0d: got %h expected %h", i, act_log[i], exp_log[i]);
            end
        end
        tick(2);
    endtask

    task automatic test_latency_setup();
        clear_logs();
        data_pins = 4'h9;
        tick(1);
        strobe = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            checks++;
            if (bl_we !== (i == 2)) begin
                errors++;
                $display("FAIL latency_edge_k%0d: got %b expected %b", i, bl_we, (i == 2));
            end
            if (i == 2) begin
                checks++;
                if (bl_data !== 4'h9) begin
                    errors++;
                    $display("FAIL latency_data: got %h expected 9", bl_data);
                end
            end
            if (i == 4) data_pins = 4'h5;
        end
        model_strobe(4'h9);
        strobe = 1'b0;
        tick(4);
        checks++;
        if (act_log.size() != 1 || act_log[0] !== exp_log[0] || bl_data !== 4'h9) begin
            errors++;
            $display("FAIL latency_hold: got n=%0d bl_data=%h expected n=1 bl_data=9",
                     act_log.size(), bl_data);
        end
    endtask

    initial begin
        test_reset();
        test_request_latency();
        test_full_load();
        test_done_strobes();
        test_release_latency();
        test_abort();
        test_idle_strobe();
        test_reset_mid_load();
        test_latency_setup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
